// File: rtl/crossbar_cfg_loader_if.sv
// crossbar_cfg_loader_if
//   Valid/ready beat channel that carries per-output select values from the
//   PE configuration controller into crossbar_cfg_loader.
//   Signals:
//     valid  - beat valid (controller -> loader)
//     data   - select value for the current output index (controller -> loader)
//     ready  - loader can accept a beat this cycle (loader -> controller)
//   Modports: master = configuration controller, slave = loader.

interface crossbar_cfg_loader_if #(
    parameter int SEL_W = 4
);
    logic             valid;
    logic [SEL_W-1:0] data;
    logic             ready;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/crossbar_cfg_loader.sv
// crossbar_cfg_loader
//   Configuration-side driver for the PE routing crossbar. Select values are
//   streamed into a shadow bank one beat per output, range-checked against
//   NUM_INPUTS, and committed atomically to select_o once the whole set has
//   arrived, so routing never changes in the middle of a load.
//
//   Optional feature macro: CB_CFG_READBACK_EN
//     defined   - adds rd_idx_i / rd_data_o, a registered readback of the
//                 shadow bank (indices >= NUM_OUTPUTS read as 0).
//     undefined - no readback ports; the shadow bank is write-only.
//
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     start_i     - begin a load (honoured in IDLE only)
//     abort_i     - abandon the current load (honoured in LOAD only)
//     disable_i   - force cb_en_o low on the next edge
//     cfg         - beat channel (slave modport: valid, data in; ready out)
//     select_o    - active select bank, output k in bits [k*SEL_W +: SEL_W]
//     cb_en_o     - crossbar enable
//     busy_o      - high while in LOAD or COMMIT
//     done_o      - one-cycle pulse when a commit is applied
//     err_o       - sticky load-rejected flag, cleared by the next start

module crossbar_cfg_loader #(
    parameter  int NUM_INPUTS  = 14,
    parameter  int NUM_OUTPUTS = 16,
    localparam int SEL_W       = $clog2(NUM_INPUTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic                         disable_i,
    crossbar_cfg_loader_if.slave         cfg,
    output logic [NUM_OUTPUTS*SEL_W-1:0] select_o,
    output logic                         cb_en_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
`ifdef CB_CFG_READBACK_EN
    ,
    input  logic [$clog2(NUM_OUTPUTS)-1:0] rd_idx_i,
    output logic [SEL_W-1:0]               rd_data_o
`endif
);

    localparam int IDX_W = $clog2(NUM_OUTPUTS);
    localparam int CNT_W = $clog2(NUM_OUTPUTS + 1);

    // One extra bit so a power-of-two NUM_INPUTS does not truncate to 0.
    localparam logic [SEL_W:0]   IN_LIMIT = (SEL_W + 1)'(NUM_INPUTS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OUTPUTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_err;
    logic [SEL_W-1:0] shadow [NUM_OUTPUTS];

    // Abort wins over a coincident beat: the beat is simply not taken.
    assign cfg.ready = (state == LOAD) && !abort_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            load_err <= 1'b0;
            select_o <= '0;
            cb_en_o  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        load_err <= 1'b0;
                        err_o    <= 1'b0;
                        busy_o   <= 1'b1;
                    end
                end

                LOAD: begin
                    if (abort_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (cfg.valid) begin
                        shadow[cnt[IDX_W-1:0]] <= cfg.data;
                        cnt                    <= cnt + 1'b1;
                        if ({1'b0, cfg.data} >= IN_LIMIT) begin
                            load_err <= 1'b1;
                        end
                        if (cnt == LAST_IDX) begin
                            state <= COMMIT;
                        end
                    end
                end

                COMMIT: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (load_err) begin
                        err_o <= 1'b1;
                    end else begin
                        for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
                            select_o[k*SEL_W +: SEL_W] <= shadow[k];
                        end
                        cb_en_o <= 1'b1;
                        done_o  <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase

            // Placed after the FSM so it overrides a same-cycle commit enable.
            if (disable_i) begin
                cb_en_o <= 1'b0;
            end
        end
    end

`ifdef CB_CFG_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o <= '0;
        end else if (int'(rd_idx_i) < NUM_OUTPUTS) begin
            rd_data_o <= shadow[rd_idx_i];
        end else begin
            rd_data_o <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_crossbar_cfg_loader.sv
// tb_crossbar_cfg_loader
//   Directed bench for crossbar_cfg_loader (NUM_INPUTS=14, NUM_OUTPUTS=16,
//   SEL_W=4). Inputs change on the falling edge; outputs are sampled on the
//   falling edge. Build with +define+CB_CFG_READBACK_EN to also cover the
//   shadow readback ports.

module tb_crossbar_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic        disable_i;
    logic [63:0] select_o;
    logic        cb_en_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
`ifdef CB_CFG_READBACK_EN
    logic [3:0]  rd_idx_i;
    logic [3:0]  rd_data_o;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    crossbar_cfg_loader_if #(.SEL_W(4)) cfg ();

    crossbar_cfg_loader #(
        .NUM_INPUTS (14),
        .NUM_OUTPUTS(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .disable_i(disable_i),
        .cfg      (cfg),
        .select_o (select_o),
        .cb_en_o  (cb_en_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o)
`ifdef CB_CFG_READBACK_EN
        ,
        .rd_idx_i (rd_idx_i),
        .rd_data_o(rd_data_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_sel"},   select_o,  64'h0);
        check({tag, "_en"},    cb_en_o,   1'b0);
        check({tag, "_ready"}, cfg.ready, 1'b0);
        check({tag, "_busy"},  busy_o,    1'b0);
        check({tag, "_done"},  done_o,    1'b0);
        check({tag, "_err"},   err_o,     1'b0);
    endtask

    // Pulse start for one cycle; returns at the falling edge of the first LOAD cycle.
    task automatic do_start(input string tag);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "_start_busy"},  busy_o,    1'b1);
        check({tag, "_start_ready"}, cfg.ready, 1'b1);
        check({tag, "_start_err"},   err_o,     1'b0);
    endtask

    // Stream 16 beats (beat k = pack[4k+3:4k]); with gaps, valid idles one
    // cycle between beats. Returns at the falling edge of cycle L+1 (COMMIT).
    task automatic run_load(input logic [63:0] pack, input bit gaps);
        for (int k = 0; k < 16; k++) begin
            cfg.valid = 1'b1;
            cfg.data  = pack[k*4 +: 4];
            @(negedge clk);
            if (gaps && k < 15) begin
                cfg.valid = 1'b0;
                cfg.data  = 4'hF;
                @(negedge clk);
            end
        end
        cfg.valid = 1'b0;
        cfg.data  = 4'h0;
    endtask

    logic [63:0] pack1, pack2, pack3, pack4, pack5;
    logic [63:0] exp_sel;

    initial begin
        rst_n     = 1'b0;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        disable_i = 1'b0;
        cfg.valid = 1'b0;
        cfg.data  = 4'h0;
`ifdef CB_CFG_READBACK_EN
        rd_idx_i  = 4'd0;
`endif
        for (int k = 0; k < 16; k++) begin
            pack1[k*4 +: 4] = 4'((15 - k) % 14);
            pack3[k*4 +: 4] = 4'(k % 14);
            pack4[k*4 +: 4] = 4'((k * 3) % 14);
            pack5[k*4 +: 4] = 4'((k + 5) % 14);
        end
        pack2        = pack1;
        pack2[23:20] = 4'd14;

        // Reset values
        repeat (2) @(negedge clk);
        check_idle_reset("rst");
`ifdef CB_CFG_READBACK_EN
        check("rst_rd", rd_data_o, 4'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Full back-to-back load
        do_start("l1");
        run_load(pack1, 1'b0);
        check("l1_commit_done", done_o, 1'b0);
        check("l1_commit_busy", busy_o, 1'b1);
        check("l1_commit_sel",  select_o, 64'h0);
        @(negedge clk);
        check("l1_done", done_o,   1'b1);
        check("l1_sel",  select_o, pack1);
        check("l1_en",   cb_en_o,  1'b1);
        check("l1_err",  err_o,    1'b0);
        check("l1_busy", busy_o,   1'b0);
        @(negedge clk);
        check("l1_done_pulse", done_o, 1'b0);
        exp_sel = pack1;

        // Out-of-range beat 5 rejects the load
        do_start("l2");
        run_load(pack2, 1'b0);
        @(negedge clk);
        check("l2_done", done_o,   1'b0);
        check("l2_err",  err_o,    1'b1);
        check("l2_sel",  select_o, exp_sel);
        check("l2_en",   cb_en_o,  1'b1);
        @(negedge clk);
        check("l2_err_sticky", err_o, 1'b1);

        // Next start clears err; then abort coinciding with beat 7
        do_start("ab");
        for (int k = 0; k < 7; k++) begin
            cfg.valid = 1'b1;
            cfg.data  = 4'(k + 2);
            @(negedge clk);
        end
        cfg.valid = 1'b1;
        cfg.data  = 4'd9;
        abort_i   = 1'b1;
        #1;
        check("ab_ready", cfg.ready, 1'b0);
        @(negedge clk);
        abort_i   = 1'b0;
        cfg.valid = 1'b0;
        check("ab_busy", busy_o,   1'b0);
        check("ab_sel",  select_o, exp_sel);
        check("ab_en",   cb_en_o,  1'b1);
        check("ab_err",  err_o,    1'b0);
        check("ab_idle_ready", cfg.ready, 1'b0);
        @(negedge clk);

        // valid toggling every other cycle
        do_start("gp");
        run_load(pack3, 1'b1);
        check("gp_commit_done", done_o, 1'b0);
        check("gp_commit_sel",  select_o, exp_sel);
        @(negedge clk);
        check("gp_done", done_o,   1'b1);
        check("gp_sel",  select_o, pack3);
        check("gp_en",   cb_en_o,  1'b1);
        exp_sel = pack3;
        @(negedge clk);

        // disable_i during the COMMIT cycle
        do_start("ds");
        run_load(pack4, 1'b0);
        disable_i = 1'b1;
        @(negedge clk);
        disable_i = 1'b0;
        check("ds_done", done_o,   1'b1);
        check("ds_sel",  select_o, pack4);
        check("ds_en",   cb_en_o,  1'b0);
        exp_sel = pack4;
        @(negedge clk);

        // Asynchronous reset during beat 10, then a full load succeeds
        do_start("rm");
        for (int k = 0; k < 10; k++) begin
            cfg.valid = 1'b1;
            cfg.data  = 4'(k);
            @(negedge clk);
        end
        cfg.valid = 1'b1;
        cfg.data  = 4'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_reset("rm");
        @(negedge clk);
        cfg.valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check_idle_reset("rm_after");
        do_start("l5");
        run_load(pack5, 1'b0);
        @(negedge clk);
        check("l5_done", done_o,   1'b1);
        check("l5_sel",  select_o, pack5);
        check("l5_en",   cb_en_o,  1'b1);
        check("l5_err",  err_o,    1'b0);

`ifdef CB_CFG_READBACK_EN
        rd_idx_i = 4'd3;
        @(negedge clk);
        check("rd_idx3", rd_data_o, 4'd8);
        rd_idx_i = 4'd15;
        @(negedge clk);
        check("rd_idx15", rd_data_o, 4'd6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
